// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Holds the PC, issues in-order word reads to instruction memory, tags each
// read with its PC and buffers responses in a small result FIFO. The number of
// buffered results plus reads still in flight (including reads whose responses
// will be thrown away after a redirect) never exceeds QUEUE_DEPTH.
// Optional build macro: FETCH_PERF_COUNTERS_EN adds saturating 32-bit counters
// perf_fetched_out (responses buffered) and perf_dropped_out (responses discarded).
module fetch_unit #(
  parameter int                   WORD_SIZE   = 25,
  parameter int                   QUEUE_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 request_valid_in,
  input  logic [1:0]           request_operation_in,
  input  logic [WORD_SIZE-1:0] redirect_pc_in,
  output logic                 result_valid_out,
  output logic [WORD_SIZE-1:0] result_pc_out,
  output logic [WORD_SIZE-1:0] result_instruction_out,
  output logic                 imem_req_valid_out,
  output logic [WORD_SIZE-1:0] imem_req_address_out,
  input  logic                 imem_req_ready_in,
  input  logic                 imem_resp_valid_in,
  input  logic [WORD_SIZE-1:0] imem_resp_data_in
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]          perf_fetched_out,
  output logic [31:0]          perf_dropped_out
`endif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W+1)'(QUEUE_DEPTH);

  localparam logic [1:0] OP_DEQUEUE  = 2'd0;
  localparam logic [1:0] OP_REDIRECT = 2'd2;

  logic [WORD_SIZE-1:0] pc;

  logic [WORD_SIZE-1:0] res_pc_mem    [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0] res_instr_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]     res_rd;
  logic [PTR_W-1:0]     res_wr;
  logic [CNT_W-1:0]     occupancy;

  logic [WORD_SIZE-1:0] tag_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]     tag_rd;
  logic [PTR_W-1:0]     tag_wr;
  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     drop_count;

  logic           redirect_now;
  logic           dequeue_now;
  logic [CNT_W:0] credit_sum;
  logic           accept;
  logic           resp_fire;
  logic           resp_drop;
  logic           push;
  logic           pop;

  // Request decode, credit check and FIFO handshake qualifiers.
  always_comb begin
    redirect_now = request_valid_in && (request_operation_in == OP_REDIRECT);
    dequeue_now  = request_valid_in && (request_operation_in == OP_DEQUEUE);
    credit_sum   = {1'b0, occupancy} + {1'b0, inflight};
    // Reset gating keeps the request quiet while rst_in is held.
    imem_req_valid_out   = (credit_sum < DEPTH_LIMIT) && !redirect_now && !rst_in;
    imem_req_address_out = pc;
    accept    = imem_req_valid_out && imem_req_ready_in;
    // A stray response with nothing outstanding is ignored rather than corrupting counts.
    resp_fire = imem_resp_valid_in && (inflight != '0);
    resp_drop = resp_fire && (redirect_now || (drop_count != '0));
    push      = resp_fire && !resp_drop;
    pop       = dequeue_now && (occupancy != '0) && !redirect_now;
  end

  assign result_valid_out       = (occupancy != '0);
  assign result_pc_out          = res_pc_mem[res_rd];
  assign result_instruction_out = res_instr_mem[res_rd];

  // Program counter: redirect target wins, otherwise advance on each accepted read.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)            pc <= RESET_PC;
    else if (redirect_now) pc <= redirect_pc_in;
    else if (accept)       pc <= pc + WORD_SIZE'(1);
  end

  // In-flight PC tags: written on accept, retired by every response (kept or dropped).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) tag_mem[i] <= '0;
      tag_rd <= '0;
      tag_wr <= '0;
    end else begin
      if (accept) begin
        tag_mem[tag_wr] <= pc;
        tag_wr          <= tag_wr + PTR_W'(1);
      end
      if (resp_fire) tag_rd <= tag_rd + PTR_W'(1);
    end
  end

  // Outstanding read count and the number of wrong-path responses still to discard.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inflight   <= '0;
      drop_count <= '0;
    end else begin
      case ({accept, resp_fire})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (redirect_now)
        drop_count <= inflight - CNT_W'(resp_fire);
      else if (resp_fire && (drop_count != '0))
        drop_count <= drop_count - CNT_W'(1);
    end
  end

  // Result FIFO: flushed on redirect, otherwise independent push and pop.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        res_pc_mem[i]    <= '0;
        res_instr_mem[i] <= '0;
      end
      res_rd    <= '0;
      res_wr    <= '0;
      occupancy <= '0;
    end else if (redirect_now) begin
      res_rd    <= '0;
      res_wr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        res_pc_mem[res_wr]    <= tag_mem[tag_rd];
        res_instr_mem[res_wr] <= imem_resp_data_in;
        res_wr                <= res_wr + PTR_W'(1);
      end
      if (pop) res_rd <= res_rd + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // Saturating event counters for buffered and discarded responses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_fetched_out <= '0;
      perf_dropped_out <= '0;
    end else begin
      if (push && (perf_fetched_out != '1))      perf_fetched_out <= perf_fetched_out + 32'd1;
      if (resp_drop && (perf_dropped_out != '1)) perf_dropped_out <= perf_dropped_out + 32'd1;
    end
  end
`endif

endmodule
